iter_shift_unit: RTL and testbench
==================================

Name: iter_shift_unit

Overview:
- Parametrised multi-cycle shift/rotate unit; successor to the single-cycle SHR/SHRA path in the datapath ALU.
- Adds shift-left, rotate-left and rotate-right. Width and bits-per-cycle are configurable.
- Uses a start/busy/done handshake so the control sequencer can stall its T-step while the shift runs.
- Sits beside the ALU. The result is steered into Z-low by the sequencer after `done`.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥ 2.
- SHAMT_W, 5, shift-amount width; must equal clog2(WIDTH).
- STEP, 1, maximum bits shifted per cycle; power of two, 1 ≤ STEP ≤ WIDTH.

Ports:
- Clock  input  1  system clock; all state updates on the rising edge.
- clear  input  1  asynchronous active-high reset.
- start  input  1  request; sampled only in IDLE.
- op  input  3  operation, captured with start: 000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL, 101–111 PASS.
- data_in  input  WIDTH  operand, captured with start.
- shamt  input  SHAMT_W  shift amount, captured with start; the range 0..WIDTH-1 is implicit modulo WIDTH.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle completion pulse.
- result  output  WIDTH  last completed result; held until the next completion.

Behaviour:
- Reset (clear=1, asynchronous, any state):
  - state = IDLE.
  - busy = 0, done = 0, result = 0.
  - Working register and remaining count = 0.
- States: IDLE, RUN.
- IDLE:
  - done deasserts after one cycle.
  - On an edge with start=1, capture op, data_in and shamt into the working regs.
  - remaining = shamt, busy = 1, go to RUN.
  - For PASS ops, remaining is forced to 0.
- RUN, remaining ≠ 0:
  - Shift the working reg by s = min(STEP, remaining); remaining -= s.
  - SHR: zero fill from MSB.
  - SHRA: replicate the original bit WIDTH-1 into vacated MSBs.
  - SHL: zero fill from LSB.
  - ROR/ROL: bits wrap around; no loss.
- RUN, remaining = 0:
  - result = working reg, done = 1, busy = 0, go to IDLE.
- Latency: with start sampled at edge k, done is high during the cycle after edge k + ceil(shamt/STEP) + 1.
  - shamt = 0 or PASS: done after edge k+1, result = data_in.
- result changes only at completion. Intermediate values are never visible.
- start while busy=1 is ignored; there is no queueing and no error flag.
- start=1 in the same cycle done=1 (state is IDLE) is accepted; back-to-back throughput has no bubble beyond the IDLE cycle.
- op/data_in/shamt changes while busy have no effect.
- clear mid-operation aborts immediately: result = 0, no done pulse.
- Sequential outputs only; no combinational path from start to busy or done.

Test Plan:
- Reset: clear=1 async mid-cycle -> busy=0, done=0, result=0 immediately, before the next Clock edge.
- SHRA, WIDTH=32, STEP=1, data_in=0x80000012, shamt=4 -> busy for 5 cycles; then done=1 for exactly one cycle with result=0xF8000001, which stays stable afterwards.
- Mixed ops, STEP=1:
  - SHR 0x00000018 by 3 -> 0x00000003.
  - SHL 0x00000014 by 2 -> 0x00000050.
  - ROL 0x80000001 by 1 -> 0x00000003.
  - ROR 0x00000012 by 4 -> 0x20000001.
  - Each done latency = shamt+1 cycles.
- Boundaries:
  - shamt=0, op=SHRA, data_in=0x12345678 -> done after 1 cycle, result=0x12345678.
  - op=111 with shamt=7 -> PASS, done after 1 cycle, result=data_in.
- Handshake:
  - start pulsed again 2 cycles into a shamt=10 SHR -> ignored; single done; result from the first op only.
  - start held high on the done cycle -> second op accepted; its done appears shamt2+1 cycles later.
- STEP=4 instance, SHRA 0x80000000 by 31 -> done after 9 cycles (8 steps + 1), result=0xFFFFFFFF.
- clear asserted at cycle 3 of that op -> immediate IDLE, result=0, no done; a fresh start afterwards completes normally.

Source files
------------

// File: rtl/iter_shift_unit.sv
// -----------------------------------------------------------------------------
// iter_shift_unit
//   Multi-cycle shift/rotate unit that sits beside the datapath ALU. An
//   operation is captured on start and then advanced by up to STEP bit
//   positions per clock. The final value is published on result together with
//   a one-cycle done pulse, so the control sequencer can stall its T-step
//   until the shift completes.
//
// Ports
//   Clock    in   system clock, rising-edge
//   clear    in   asynchronous active-high reset
//   start    in   request, sampled only while idle
//   op       in   3'b000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL, else PASS
//   data_in  in   operand (WIDTH)
//   shamt    in   shift amount (SHAMT_W), taken modulo WIDTH
//   busy     out  high while an operation is in progress
//   done     out  one-cycle completion pulse
//   result   out  last completed result, held until the next completion
// -----------------------------------------------------------------------------
module iter_shift_unit #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 5,
  parameter int STEP    = 1
) (
  input  logic               Clock,
  input  logic               clear,
  input  logic               start,
  input  logic [2:0]         op,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [2:0] OP_SHR  = 3'b000;
  localparam logic [2:0] OP_SHRA = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_ROR  = 3'b011;
  localparam logic [2:0] OP_ROL  = 3'b100;

  // One extra bit so that STEP == WIDTH is representable.
  localparam logic [SHAMT_W:0] STEP_W  = (SHAMT_W+1)'(STEP);
  localparam logic [SHAMT_W:0] WIDTH_W = (SHAMT_W+1)'(WIDTH);

  logic [0:0]         state_q,  state_d;
  logic [2:0]         op_q,     op_d;
  logic [WIDTH-1:0]   work_q,   work_d;
  logic [SHAMT_W-1:0] rem_q,    rem_d;
  logic               busy_q,   busy_d;
  logic               done_q,   done_d;
  logic [WIDTH-1:0]   result_q, result_d;

  logic [SHAMT_W:0]   rem_ext;
  logic [SHAMT_W:0]   step_amt;
  logic [WIDTH-1:0]   shifted;
  logic               is_pass;

  assign is_pass  = (op > OP_ROL);
  assign rem_ext  = {1'b0, rem_q};
  // Bits moved this cycle: min(STEP, remaining). Never zero while shifting,
  // so the rotate complement (WIDTH - step_amt) stays below WIDTH.
  assign step_amt = (rem_ext > STEP_W) ? STEP_W : rem_ext;

  // One partial step of the captured operation.
  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    shifted = work_q;
    case (op_q)
      OP_SHR:  shifted = work_q >> step_amt;
      // An arithmetic shift keeps bit WIDTH-1 unchanged, so repeating it
      // always replicates the original sign bit.
      OP_SHRA: shifted = $unsigned($signed(work_q) >>> step_amt);
      OP_SHL:  shifted = work_q << step_amt;
      OP_ROR:  shifted = (work_q >> step_amt) | (work_q << (WIDTH_W - step_amt));
      OP_ROL:  shifted = (work_q << step_amt) | (work_q >> (WIDTH_W - step_amt));
      default: shifted = work_q;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    work_d   = work_q;
    rem_d    = rem_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    result_d = result_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_d    = op;
          work_d  = data_in;
          rem_d   = is_pass ? '0 : shamt;
          busy_d  = 1'b1;
          state_d = S_RUN;
        end
      end
      default: begin
        if (rem_q != '0) begin
          work_d = shifted;
          rem_d  = rem_q - step_amt[SHAMT_W-1:0];
        end else begin
          // result is only ever written here, so partial values stay hidden.
          result_d = work_q;
          done_d   = 1'b1;
          busy_d   = 1'b0;
          state_d  = S_IDLE;
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge Clock or posedge clear) begin
    if (clear) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      work_q   <= '0;
      rem_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      work_q   <= work_d;
      rem_q    <= rem_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_iter_shift_unit.sv
// -----------------------------------------------------------------------------
// tb_iter_shift_unit
//   Directed bench for iter_shift_unit. Two instances share clock, clear and
//   operand inputs: dut1 steps one bit per cycle, dut4 steps four. Expected
//   results and latencies are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_iter_shift_unit;

  logic        Clock;
  logic        clear;
  logic        start1, start4;
  logic [2:0]  op;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        busy1, done1, busy4, done4;
  logic [31:0] result1, result4;

  int n_checks = 0;
  int n_fail   = 0;

  iter_shift_unit #(.WIDTH(32), .SHAMT_W(5), .STEP(1)) dut1 (
    .Clock(Clock), .clear(clear), .start(start1), .op(op), .data_in(data_in),
    .shamt(shamt), .busy(busy1), .done(done1), .result(result1)
  );

  iter_shift_unit #(.WIDTH(32), .SHAMT_W(5), .STEP(4)) dut4 (
    .Clock(Clock), .clear(clear), .start(start4), .op(op), .data_in(data_in),
    .shamt(shamt), .busy(busy4), .done(done4), .result(result4)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are sampled 1ns later.
  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  // Issue one operation and check busy span, done latency, result and that
  // done is a single-cycle pulse with result held afterwards.
  task automatic run_op(input bit use4, input logic [2:0] o, input logic [31:0] d,
                        input logic [4:0] sa, input logic [31:0] exp_res,
                        input int exp_lat, input string tag);
    int cycles;
    int busy_cnt;
    bit seen;
    op = o; data_in = d; shamt = sa;
    if (use4) start4 = 1'b1; else start1 = 1'b1;
    tick();
    start1 = 1'b0; start4 = 1'b0;
    check({tag, " busy after start"}, use4 ? busy4 : busy1, 1);
    busy_cnt = 1;
    cycles   = 0;
    seen     = 1'b0;
    while (!seen && cycles < 64) begin
      tick();
      cycles++;
      if (use4 ? done4 : done1) seen = 1'b1;
      else if (use4 ? busy4 : busy1) busy_cnt++;
    end
    check({tag, " done latency"}, cycles, exp_lat);
    check({tag, " busy cycles"}, busy_cnt, exp_lat);
    check({tag, " result"}, use4 ? result4 : result1, exp_res);
    tick();
    check({tag, " done one cycle"}, use4 ? done4 : done1, 0);
    check({tag, " result held"}, use4 ? result4 : result1, exp_res);
  endtask

  initial begin
    int n_done;
    int first;
    int cycles;
    bit seen;

    clear = 1'b1; start1 = 1'b0; start4 = 1'b0;
    op = '0; data_in = '0; shamt = '0;
    #3;
    check("reset busy", busy1, 0);
    check("reset done", done1, 0);
    check("reset result", result1, 0);
    #3 clear = 1'b0;
    tick();

    // Sign-extending shift.
    run_op(0, 3'b001, 32'h8000_0012, 5'd4,  32'hF800_0001, 5, "shra4");
    // Mixed ops, one bit per cycle.
    run_op(0, 3'b000, 32'h0000_0018, 5'd3,  32'h0000_0003, 4, "shr3");
    run_op(0, 3'b010, 32'h0000_0014, 5'd2,  32'h0000_0050, 3, "shl2");
    run_op(0, 3'b100, 32'h8000_0001, 5'd1,  32'h0000_0003, 2, "rol1");
    run_op(0, 3'b011, 32'h0000_0012, 5'd4,  32'h2000_0001, 5, "ror4");
    // Boundaries.
    run_op(0, 3'b001, 32'h1234_5678, 5'd0,  32'h1234_5678, 1, "shamt0");
    run_op(0, 3'b111, 32'hCAFE_F00D, 5'd7,  32'hCAFE_F00D, 1, "pass");
    run_op(0, 3'b000, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001, 32, "shr31");

    // start pulsed while busy must be ignored.
    op = 3'b000; data_in = 32'hFFFF_0000; shamt = 5'd10; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    n_done = 0;
    first  = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 3) begin
        op = 3'b010; data_in = 32'h0000_0001; shamt = 5'd1; start1 = 1'b1;
      end
      tick();
      if (c == 3) start1 = 1'b0;
      if (done1) begin
        n_done++;
        if (first == 0) first = c;
      end
    end
    check("ignore latency", first, 11);
    check("ignore single done", n_done, 1);
    check("ignore result", result1, 32'h003F_FFC0);

    // start held high: ignored while busy, accepted on the done cycle. The
    // operands change while busy and are picked up only by the second op.
    op = 3'b010; data_in = 32'h0000_0001; shamt = 5'd3; start1 = 1'b1;
    tick();
    op = 3'b011; data_in = 32'h0000_0001; shamt = 5'd2;
    cycles = 0; seen = 1'b0;
    while (!seen && cycles < 64) begin
      tick();
      cycles++;
      if (done1) seen = 1'b1;
    end
    check("b2b first latency", cycles, 4);
    check("b2b first result", result1, 32'h0000_0008);
    tick();
    start1 = 1'b0;
    check("b2b second accepted", busy1, 1);
    check("b2b done dropped", done1, 0);
    cycles = 0; seen = 1'b0;
    while (!seen && cycles < 64) begin
      tick();
      cycles++;
      if (done1) seen = 1'b1;
    end
    check("b2b second latency", cycles, 3);
    check("b2b second result", result1, 32'h4000_0000);
    tick();

    // Four bits per cycle: 31 = 8 steps, plus the completion cycle.
    run_op(1, 3'b001, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 9, "step4 shra31");

    // Abort mid-operation with an asynchronous clear.
    op = 3'b001; data_in = 32'h8000_0000; shamt = 5'd31; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    tick();
    #2 clear = 1'b1;
    #1;
    check("abort busy", busy4, 0);
    check("abort done", done4, 0);
    check("abort result", result4, 0);
    check("abort other result", result1, 0);
    #1 clear = 1'b0;
    n_done = 0;
    for (int c = 0; c < 12; c++) begin
      tick();
      if (done4) n_done++;
    end
    check("abort no done", n_done, 0);
    check("abort stays idle", busy4, 0);

    // Fresh operations after the abort; the last step is shorter than STEP.
    run_op(1, 3'b100, 32'h0000_0001, 5'd6, 32'h0000_0040, 3, "step4 rol6");
    run_op(1, 3'b011, 32'h0000_0012, 5'd5, 32'h9000_0000, 3, "step4 ror5");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
